// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the two-master memory arbiter.
//   state_t            : arbiter FSM states (IDLE / REQ / WAIT)
//   MST_IFU / MST_LSU  : master identifiers, also used as the grant index
//   DEF_TIMEOUT_CYCLES : default response timeout (timeout build only)
// -----------------------------------------------------------------------------
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam logic MST_IFU = 1'b0;
  localparam logic MST_LSU = 1'b1;

  localparam int DEF_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
// Bundles the IFU request/response port, the LSU request/response port and the
// shared downstream memory port.
//   slave  : arbiter view (accepts IFU/LSU requests, drives the memory port)
//   master : environment view (IFU, LSU and memory model)
// -----------------------------------------------------------------------------
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int MASK_W = DATA_W / 8;

  // IFU
  logic              ifu_req_valid;
  logic              ifu_req_ready;
  logic [ADDR_W-1:0] ifu_addr;
  logic              ifu_rsp_valid;
  logic [DATA_W-1:0] ifu_rdata;
  logic              ifu_rsp_err;

  // LSU
  logic              lsu_req_valid;
  logic              lsu_req_ready;
  logic [ADDR_W-1:0] lsu_addr;
  logic              lsu_wen;
  logic [DATA_W-1:0] lsu_wdata;
  logic [MASK_W-1:0] lsu_wmask;
  logic              lsu_rsp_valid;
  logic [DATA_W-1:0] lsu_rdata;
  logic              lsu_rsp_err;

  // Memory
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wen;
  logic [DATA_W-1:0] mem_wdata;
  logic [MASK_W-1:0] mem_wmask;
  logic              mem_rsp_valid;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  ifu_req_valid, ifu_addr,
    output ifu_req_ready, ifu_rsp_valid, ifu_rdata, ifu_rsp_err,
    input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    output lsu_req_ready, lsu_rsp_valid, lsu_rdata, lsu_rsp_err,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    input  mem_req_ready, mem_rsp_valid, mem_rdata
  );

  modport master (
    output ifu_req_valid, ifu_addr,
    input  ifu_req_ready, ifu_rsp_valid, ifu_rdata, ifu_rsp_err,
    output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    input  lsu_req_ready, lsu_rsp_valid, lsu_rdata, lsu_rsp_err,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    output mem_req_ready, mem_rsp_valid, mem_rdata
  );

endinterface

// File: rtl/mem_arb_rr.sv
// -----------------------------------------------------------------------------
// mem_arb_rr
// Combinational 2-way round-robin picker.
//   ifu_valid, lsu_valid : request valids
//   last_grant           : master granted most recently (MST_IFU / MST_LSU)
//   grant                : one-hot, bit 0 = IFU, bit 1 = LSU, 0 when idle
// -----------------------------------------------------------------------------
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic       ifu_valid,
  input  logic       lsu_valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (ifu_valid && lsu_valid) begin
      // On a tie the master that did not win last time goes first.
      grant = (last_grant == MST_IFU) ? 2'b10 : 2'b01;
    end else if (ifu_valid) begin
      grant = 2'b01;
    end else if (lsu_valid) begin
      grant = 2'b10;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Two-master (IFU, LSU) to one-slave memory arbiter with a single outstanding
// transaction: accept in IDLE, present downstream in REQ, wait for the
// response in WAIT and route it combinationally to the owner.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset (aborts any transaction silently)
//   bus : mem_arbiter_if.slave (IFU port, LSU port, memory port)
// Build option: define MEM_ARB_TIMEOUT_EN to add a response timeout of
// TIMEOUT_CYCLES cycles (REQ + WAIT), answered with rsp_err=1 and rdata=0.
// Without it the arbiter waits indefinitely and rsp_err is always 0.
// -----------------------------------------------------------------------------
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  localparam int MASK_W = DATA_W / 8;

  state_t            state_q, state_d;
  logic              owner_q;
  logic              last_grant_q;
  logic [ADDR_W-1:0] addr_q;
  logic              wen_q;
  logic [DATA_W-1:0] wdata_q;
  logic [MASK_W-1:0] wmask_q;

  logic [1:0]        grant;
  logic              accept;
  logic              rsp_fire;
  logic              rsp_err;
  logic              expire;
  logic              req_ready_ifu;
  logic              req_ready_lsu;
  logic              req_valid;
  logic [DATA_W-1:0] rsp_rdata;

  mem_arb_rr u_rr (
    .ifu_valid  (bus.ifu_req_valid),
    .lsu_valid  (bus.lsu_req_valid),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  // cnt_q counts the REQ/WAIT cycles already completed, so the current cycle
  // is the TIMEOUT_CYCLES-th one when cnt_q reaches TIMEOUT_CYCLES-1. Using >=
  // also covers a handshake that lands exactly on the last counted cycle: the
  // following WAIT cycle then expires instead of the counter wrapping.
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= '0;
    end else if (state_q == REQ || state_q == WAIT) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign expire = (cnt_q >= CNT_W'(TIMEOUT_CYCLES - 1));
`else
  // TIMEOUT_CYCLES only has meaning in the timeout build.
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = (TIMEOUT_CYCLES == 0);
  assign expire = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    req_ready_ifu = 1'b0;
    req_ready_lsu = 1'b0;
    accept        = 1'b0;
    req_valid     = 1'b0;
    rsp_fire      = 1'b0;
    rsp_err       = 1'b0;
    case (state_q)
      IDLE: begin
        // A grant implies the matching valid, so a grant is a handshake.
        req_ready_ifu = grant[0];
        req_ready_lsu = grant[1];
        accept        = |grant;
        if (accept) state_d = REQ;
      end
      REQ: begin
        req_valid = 1'b1;
        if (bus.mem_req_ready) begin
          state_d = WAIT;
        end else if (expire) begin
          rsp_fire = 1'b1;
          rsp_err  = 1'b1;
          state_d  = IDLE;
        end
      end
      WAIT: begin
        // A response arriving on the expiry cycle takes priority.
        if (bus.mem_rsp_valid) begin
          rsp_fire = 1'b1;
          state_d  = IDLE;
        end else if (expire) begin
          rsp_fire = 1'b1;
          rsp_err  = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Owner, round-robin history and the request fields are captured on accept.
  // IFU fetches never write, so its write fields are latched as zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q      <= MST_IFU;
      last_grant_q <= MST_IFU;
      addr_q       <= '0;
      wen_q        <= 1'b0;
      wdata_q      <= '0;
      wmask_q      <= '0;
    end else if (accept) begin
      owner_q      <= grant[1];
      last_grant_q <= grant[1];
      if (grant[1]) begin
        addr_q  <= bus.lsu_addr;
        wen_q   <= bus.lsu_wen;
        wdata_q <= bus.lsu_wdata;
        wmask_q <= bus.lsu_wmask;
      end else begin
        addr_q  <= bus.ifu_addr;
        wen_q   <= 1'b0;
        wdata_q <= '0;
        wmask_q <= '0;
      end
    end
  end

  assign bus.ifu_req_ready = req_ready_ifu;
  assign bus.lsu_req_ready = req_ready_lsu;

  assign bus.mem_req_valid = req_valid;
  assign bus.mem_addr      = addr_q;
  assign bus.mem_wen       = wen_q;
  assign bus.mem_wdata     = wdata_q;
  assign bus.mem_wmask     = wmask_q;

  // Response routing: only the owner sees the pulse; everything else reads 0.
  assign rsp_rdata = rsp_err ? '0 : bus.mem_rdata;

  assign bus.ifu_rsp_valid = rsp_fire && (owner_q == MST_IFU);
  assign bus.ifu_rdata     = bus.ifu_rsp_valid ? rsp_rdata : '0;
  assign bus.ifu_rsp_err   = bus.ifu_rsp_valid && rsp_err;

  assign bus.lsu_rsp_valid = rsp_fire && (owner_q == MST_LSU);
  assign bus.lsu_rdata     = bus.lsu_rsp_valid ? rsp_rdata : '0;
  assign bus.lsu_rsp_err   = bus.lsu_rsp_valid && rsp_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Scoreboard bench for mem_arbiter: per-master command queues feed request
// drivers, a memory model answers one cycle after each downstream handshake,
// and negedge monitors compare downstream requests and routed responses
// against queues of hand-computed expectations.
// With MEM_ARB_TIMEOUT_EN defined the DUT is built with TIMEOUT_CYCLES=8 and
// the timeout scenario is added.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 255;
`endif

  typedef struct packed {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } req_t;

  typedef struct packed {
    logic        mst;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  logic clk = 1'b0;
  logic rst;
  logic mute;
  int   stray_req;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_arbiter #(
    .ADDR_W         (ADDR_W),
    .DATA_W         (DATA_W),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  req_t        ifu_cmd_q[$];
  req_t        lsu_cmd_q[$];
  req_t        exp_req_q[$];
  rsp_t        exp_rsp_q[$];
  logic [31:0] mem_data_q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [139:0] outs();
    return {bus.ifu_req_ready, bus.lsu_req_ready, bus.ifu_rsp_valid, bus.lsu_rsp_valid,
            bus.ifu_rdata, bus.lsu_rdata, bus.ifu_rsp_err, bus.lsu_rsp_err,
            bus.mem_req_valid, bus.mem_addr, bus.mem_wen, bus.mem_wdata, bus.mem_wmask};
  endfunction

  function automatic req_t mk_req(input logic [31:0] a, input logic w,
                                  input logic [31:0] d, input logic [3:0] m);
    req_t r;
    r.addr = a; r.wen = w; r.wdata = d; r.wmask = m;
    return r;
  endfunction

  function automatic rsp_t mk_rsp(input logic m, input logic [31:0] d, input logic e);
    rsp_t r;
    r.mst = m; r.rdata = d; r.err = e;
    return r;
  endfunction

  // IFU driver: holds valid on the queue head until it is accepted.
  initial begin
    bus.ifu_req_valid = 1'b0;
    bus.ifu_addr      = '0;
    forever begin
      @(posedge clk);
      if (bus.ifu_req_valid && bus.ifu_req_ready && ifu_cmd_q.size() > 0)
        void'(ifu_cmd_q.pop_front());
      #1;
      if (ifu_cmd_q.size() > 0) begin
        bus.ifu_req_valid = 1'b1;
        bus.ifu_addr      = ifu_cmd_q[0].addr;
      end else begin
        bus.ifu_req_valid = 1'b0;
        bus.ifu_addr      = '0;
      end
    end
  end

  // LSU driver
  initial begin
    bus.lsu_req_valid = 1'b0;
    bus.lsu_addr      = '0;
    bus.lsu_wen       = 1'b0;
    bus.lsu_wdata     = '0;
    bus.lsu_wmask     = '0;
    forever begin
      @(posedge clk);
      if (bus.lsu_req_valid && bus.lsu_req_ready && lsu_cmd_q.size() > 0)
        void'(lsu_cmd_q.pop_front());
      #1;
      if (lsu_cmd_q.size() > 0) begin
        bus.lsu_req_valid = 1'b1;
        bus.lsu_addr      = lsu_cmd_q[0].addr;
        bus.lsu_wen       = lsu_cmd_q[0].wen;
        bus.lsu_wdata     = lsu_cmd_q[0].wdata;
        bus.lsu_wmask     = lsu_cmd_q[0].wmask;
      end else begin
        bus.lsu_req_valid = 1'b0;
        bus.lsu_addr      = '0;
        bus.lsu_wen       = 1'b0;
        bus.lsu_wdata     = '0;
        bus.lsu_wmask     = '0;
      end
    end
  end

  // Memory model: responds one cycle after a handshake unless muted; can also
  // inject a single stray response on request.
  initial begin
    logic hs;
    int   stray_seen;
    stray_seen        = 0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rdata     = '0;
    forever begin
      @(posedge clk);
      hs = bus.mem_req_valid && bus.mem_req_ready;
      #1;
      if (hs && !mute && mem_data_q.size() > 0) begin
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rdata     = mem_data_q.pop_front();
      end else if (stray_seen != stray_req) begin
        stray_seen        = stray_req;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rdata     = 32'hBAD0_BAD0;
      end else begin
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rdata     = '0;
      end
    end
  end

  // Monitor: downstream requests and routed responses against the scoreboard.
  initial begin
    rsp_t e;
    req_t r;
    forever begin
      @(negedge clk);
      if (bus.ifu_rsp_valid || bus.lsu_rsp_valid) begin
        if (bus.ifu_rsp_valid && bus.lsu_rsp_valid) begin
          chk("rsp_both", {bus.ifu_rsp_valid, bus.lsu_rsp_valid}, 2'b00);
        end else if (exp_rsp_q.size() == 0) begin
          chk("rsp_unexpected", {bus.ifu_rsp_valid, bus.lsu_rsp_valid}, 2'b00);
        end else begin
          e = exp_rsp_q.pop_front();
          chk("rsp_owner", bus.lsu_rsp_valid, e.mst);
          if (bus.lsu_rsp_valid) begin
            chk("rsp_rdata", bus.lsu_rdata, e.rdata);
            chk("rsp_err", bus.lsu_rsp_err, e.err);
            chk("rsp_other", {bus.ifu_rdata, bus.ifu_rsp_err}, 0);
          end else begin
            chk("rsp_rdata", bus.ifu_rdata, e.rdata);
            chk("rsp_err", bus.ifu_rsp_err, e.err);
            chk("rsp_other", {bus.lsu_rdata, bus.lsu_rsp_err}, 0);
          end
        end
      end
      if (bus.mem_req_valid && bus.mem_req_ready) begin
        if (exp_req_q.size() == 0) begin
          chk("req_unexpected", bus.mem_req_valid, 1'b0);
        end else begin
          r = exp_req_q.pop_front();
          chk("mem_req", {bus.mem_addr, bus.mem_wen, bus.mem_wdata, bus.mem_wmask}, r);
        end
      end
    end
  end

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((ifu_cmd_q.size() + lsu_cmd_q.size() + exp_req_q.size() + exp_rsp_q.size()) != 0
           && n < 300) begin
      @(posedge clk);
      n++;
    end
    chk(name, ifu_cmd_q.size() + lsu_cmd_q.size() + exp_req_q.size() + exp_rsp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    rst               = 1'b1;
    mute              = 1'b0;
    stray_req         = 0;
    bus.mem_req_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", outs(), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // IFU-only read with cycle-level latency checks
    ifu_cmd_q.push_back(mk_req(32'h8000_0000, 1'b0, 32'h0, 4'h0));
    exp_req_q.push_back(mk_req(32'h8000_0000, 1'b0, 32'h0, 4'h0));
    mem_data_q.push_back(32'h0000_0413);
    exp_rsp_q.push_back(mk_rsp(MST_IFU, 32'h0000_0413, 1'b0));
    n = 0;
    @(negedge clk);
    while (!bus.ifu_req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t1_ifu_ready", bus.ifu_req_ready, 1'b1);
    chk("t1_c0", {bus.lsu_req_ready, bus.mem_req_valid}, 2'b00);
    @(negedge clk);
    chk("t1_c1_mem", {bus.mem_req_valid, bus.mem_wen, bus.ifu_req_ready}, 3'b100);
    @(negedge clk);
    chk("t1_c2_rsp", {bus.ifu_rsp_valid, bus.lsu_rsp_valid}, 2'b10);
    @(negedge clk);
    chk("t1_c3_idle", {bus.ifu_rsp_valid, bus.mem_req_valid}, 2'b00);
    drain("t1_drain");

    // Simultaneous requests: first tie after reset goes to LSU
    lsu_cmd_q.push_back(mk_req(32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF));
    ifu_cmd_q.push_back(mk_req(32'h8000_0004, 1'b0, 32'h0, 4'h0));
    exp_req_q.push_back(mk_req(32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF));
    exp_req_q.push_back(mk_req(32'h8000_0004, 1'b0, 32'h0, 4'h0));
    mem_data_q.push_back(32'h0000_0000);
    mem_data_q.push_back(32'h0000_0013);
    exp_rsp_q.push_back(mk_rsp(MST_LSU, 32'h0000_0000, 1'b0));
    exp_rsp_q.push_back(mk_rsp(MST_IFU, 32'h0000_0013, 1'b0));
    drain("t2_drain");

    // Sustained contention: LSU, IFU, LSU, IFU, LSU, IFU
    for (int i = 0; i < 3; i++) begin
      lsu_cmd_q.push_back(mk_req(32'h8000_2000 + 32'(i * 4), 1'b0, 32'h0, 4'h0));
      ifu_cmd_q.push_back(mk_req(32'h8000_0100 + 32'(i * 4), 1'b0, 32'h0, 4'h0));
      exp_req_q.push_back(mk_req(32'h8000_2000 + 32'(i * 4), 1'b0, 32'h0, 4'h0));
      exp_req_q.push_back(mk_req(32'h8000_0100 + 32'(i * 4), 1'b0, 32'h0, 4'h0));
      mem_data_q.push_back(32'hA000_0000 + 32'(2 * i));
      mem_data_q.push_back(32'hA000_0001 + 32'(2 * i));
      exp_rsp_q.push_back(mk_rsp(MST_LSU, 32'hA000_0000 + 32'(2 * i), 1'b0));
      exp_rsp_q.push_back(mk_rsp(MST_IFU, 32'hA000_0001 + 32'(2 * i), 1'b0));
    end
    drain("t3_drain");

    // Backpressure: request held stable, no new grants while stalled
    bus.mem_req_ready = 1'b0;
    lsu_cmd_q.push_back(mk_req(32'h8000_3000, 1'b1, 32'h1234_5678, 4'h3));
    ifu_cmd_q.push_back(mk_req(32'h8000_0400, 1'b0, 32'h0, 4'h0));
    exp_req_q.push_back(mk_req(32'h8000_3000, 1'b1, 32'h1234_5678, 4'h3));
    exp_req_q.push_back(mk_req(32'h8000_0400, 1'b0, 32'h0, 4'h0));
    mem_data_q.push_back(32'h0000_0000);
    mem_data_q.push_back(32'h0000_0077);
    exp_rsp_q.push_back(mk_rsp(MST_LSU, 32'h0000_0000, 1'b0));
    exp_rsp_q.push_back(mk_rsp(MST_IFU, 32'h0000_0077, 1'b0));
    n = 0;
    @(negedge clk);
    while (!bus.mem_req_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold", {bus.mem_req_valid, bus.mem_addr, bus.mem_wen, bus.mem_wdata, bus.mem_wmask},
          {1'b1, 32'h8000_3000, 1'b1, 32'h1234_5678, 4'h3});
      chk("bp_ready", {bus.ifu_req_ready, bus.lsu_req_ready}, 2'b00);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    bus.mem_req_ready = 1'b1;
    drain("t4_drain");

    // Stray response in IDLE produces no pulse
    stray_req++;
    n = 0;
    @(negedge clk);
    while (!bus.mem_rsp_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("stray_seen", bus.mem_rsp_valid, 1'b1);
    chk("stray_ignored", {bus.ifu_rsp_valid, bus.lsu_rsp_valid, bus.ifu_rdata, bus.lsu_rdata}, 0);

    // Async reset while in WAIT aborts silently
    @(posedge clk);
    #1;
    mute = 1'b1;
    ifu_cmd_q.push_back(mk_req(32'h8000_0200, 1'b0, 32'h0, 4'h0));
    exp_req_q.push_back(mk_req(32'h8000_0200, 1'b0, 32'h0, 4'h0));
    n = 0;
    @(negedge clk);
    while (!(bus.mem_req_valid && bus.mem_req_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rst_reach_req", bus.mem_req_valid, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_async_outputs", outs(), 0);
    @(negedge clk);
    chk("rst_hold_outputs", outs(), 0);
    @(posedge clk);
    #1;
    rst  = 1'b0;
    mute = 1'b0;

    // Normal service after reset; tie goes to LSU again
    lsu_cmd_q.push_back(mk_req(32'h8000_4000, 1'b0, 32'h0, 4'h0));
    ifu_cmd_q.push_back(mk_req(32'h8000_0300, 1'b0, 32'h0, 4'h0));
    exp_req_q.push_back(mk_req(32'h8000_4000, 1'b0, 32'h0, 4'h0));
    exp_req_q.push_back(mk_req(32'h8000_0300, 1'b0, 32'h0, 4'h0));
    mem_data_q.push_back(32'h0000_0011);
    mem_data_q.push_back(32'h0000_0022);
    exp_rsp_q.push_back(mk_rsp(MST_LSU, 32'h0000_0011, 1'b0));
    exp_rsp_q.push_back(mk_rsp(MST_IFU, 32'h0000_0022, 1'b0));
    drain("t5_drain");

`ifdef MEM_ARB_TIMEOUT_EN
    // Memory never answers: error response on the 8th REQ/WAIT cycle
    mute = 1'b1;
    lsu_cmd_q.push_back(mk_req(32'h8000_5000, 1'b0, 32'h0, 4'h0));
    exp_req_q.push_back(mk_req(32'h8000_5000, 1'b0, 32'h0, 4'h0));
    exp_rsp_q.push_back(mk_rsp(MST_LSU, 32'h0000_0000, 1'b1));
    n = 0;
    @(negedge clk);
    while (!bus.mem_req_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    n = 1;
    while (!bus.lsu_rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("to_cycle", n, 8);
    @(posedge clk);
    #1;
    mute = 1'b0;
    stray_req++;
    repeat (3) @(posedge clk);
    #1;
    drain("t6_drain");
`endif

    drain("final_drain");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-master, one-slave arbiter. The IFU instruction-fetch port and the LSU load/store port share a single memory port (DPI pmem or bus bridge).
- Sequences one outstanding transaction at a time: accept, issue downstream, wait for the response, route it back to the owner.
- Sits between ifu/lsu and the memory interface in the multi-cycle core. It replaces the direct lsu-to-memory wiring.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; wmask width is DATA_W/8
- TIMEOUT_CYCLES, 255, cycles in REQ+WAIT before an error response (used only with MEM_ARB_TIMEOUT_EN)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- ifu_req_valid  in  1  fetch request
- ifu_req_ready  out  1  fetch request accepted
- ifu_addr  in  ADDR_W  fetch address
- ifu_rsp_valid  out  1  fetch response, 1-cycle pulse
- ifu_rdata  out  DATA_W  fetch data
- ifu_rsp_err  out  1  fetch error, qualified by ifu_rsp_valid
- lsu_req_valid  in  1  load/store request
- lsu_req_ready  out  1  load/store request accepted
- lsu_addr  in  ADDR_W  access address
- lsu_wen  in  1  1 = store
- lsu_wdata  in  DATA_W  store data
- lsu_wmask  in  DATA_W/8  byte enables
- lsu_rsp_valid  out  1  response pulse, for loads and stores
- lsu_rdata  out  DATA_W  load data
- lsu_rsp_err  out  1  error, qualified by lsu_rsp_valid
- mem_req_valid  out  1  downstream request
- mem_req_ready  in  1  downstream accept
- mem_addr  out  ADDR_W  latched address
- mem_wen  out  1  latched write enable; forced 0 for IFU
- mem_wdata  out  DATA_W  latched store data; 0 for IFU
- mem_wmask  out  DATA_W/8  latched mask; 0 for IFU
- mem_rsp_valid  in  1  downstream response, for reads and writes
- mem_rdata  in  DATA_W  downstream read data

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, owner=IFU, last_grant=IFU, latched fields=0.
  - All outputs 0.
  - Reset mid-transaction aborts it silently; no response is emitted.
- State IDLE:
  - req_ready is driven combinationally to the winner only, and only in IDLE.
  - If only one valid is high, it wins.
  - If both are high, round-robin: the master not equal to last_grant wins. After reset the first tie goes to LSU.
  - On a valid&ready handshake: latch addr/wen/wdata/wmask and owner, update last_grant, go to REQ next cycle.
- State REQ:
  - mem_req_valid=1 with the latched fields, stable until accepted.
  - mem_req_valid&mem_req_ready goes to WAIT.
  - mem_rsp_valid in REQ is ignored.
- State WAIT:
  - When mem_rsp_valid=1, the owner's rsp_valid=1 and rdata=mem_rdata in the same cycle (combinational route), rsp_err=0. Go to IDLE next cycle.
  - The non-owner's rsp_valid stays 0 and its rdata is 0.
- Minimum latency: handshake at cycle 0, mem_req_valid at cycle 1, earliest response at cycle 2. The next request can be accepted at cycle 3.
- Requesters must hold valid until ready. The arbiter never drops an accepted request.
- A new request cannot be accepted in the same cycle as a response; there is one IDLE bubble per transaction.
- mem_rsp_valid in IDLE (stray or late) is ignored. It produces no output pulse.
- Response ports have no backpressure; requesters always accept a response.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on REQ entry and increments each cycle in REQ or WAIT.
  - When the counter equals TIMEOUT_CYCLES with no handshake or response that cycle, the owner gets rsp_valid=1, rsp_err=1, rdata=0, and the arbiter returns to IDLE.
  - A response arriving in the same cycle as expiry wins: normal, err=0.
  - A late response after timeout is ignored in IDLE.
- Undefined: no counter; the arbiter waits indefinitely; ifu_rsp_err and lsu_rsp_err are tied 0.

Decomposition:
- Package mem_arb_pkg:
  - state enum IDLE/REQ/WAIT.
  - Master id constants MST_IFU=0, MST_LSU=1.
  - Default TIMEOUT_CYCLES constant.
- Sub-module mem_arb_rr: 2-way round-robin picker.
  - Inputs: two valids, last_grant.
  - Outputs: one-hot grant.
  - Purely combinational.
- Timeout counter and FSM stay in mem_arbiter.

Test Plan:
- IFU-only read: ifu addr=0x80000000, memory ready immediately, rsp at cycle 2 with 0x00000413 -> ifu_rsp_valid pulse with rdata=0x00000413, lsu_rsp_valid=0, mem_wen=0.
- Simultaneous requests after reset: IFU 0x80000004 and LSU store 0x80001000, wdata 0xDEADBEEF, mask 0xF -> LSU granted first with mem_wen=1 and mask 0xF; IFU granted next; each rsp routed only to its owner.
- Sustained contention over 6 transactions -> grants alternate LSU, IFU, LSU, IFU, LSU, IFU.
- Backpressure: mem_req_ready low for 5 cycles -> mem_req_valid and fields stable; both req_ready=0 throughout.
- Stray mem_rsp_valid in IDLE, and async rst asserted in WAIT -> no rsp pulses; all outputs 0 immediately; next request served normally.
- With MEM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, memory never responds -> owner gets rsp_valid=1, rsp_err=1, rdata=0 on the 8th counted cycle; a later mem_rsp_valid is ignored.
